// File: rtl/vproc_pkg.sv
// ---------------------------------------------------------------------------
// vproc_pkg
//   Shared types for the vproc memory arbiter.
//   - req_id_e : identifies which requester owns a memory transaction.
//   - other_req: returns the requester that is not the given one. The
//                round-robin pointer uses it to hand priority across.
// ---------------------------------------------------------------------------
package vproc_pkg;

  typedef enum logic {
    REQ_INSTR = 1'b0,
    REQ_DATA  = 1'b1
  } req_id_e;

  localparam int unsigned REQ_ID_W = 1;

  function automatic req_id_e other_req(input req_id_e id);
    return (id == REQ_INSTR) ? REQ_DATA : REQ_INSTR;
  endfunction

endpackage

// File: rtl/vproc_mem_arb_fifo.sv
// ---------------------------------------------------------------------------
// vproc_mem_arb_fifo
//   Small in-order FIFO. The arbiter uses it to record which requester owns
//   each outstanding memory request. It is built from flops; there is no
//   memory macro.
//
// Ports
//   clk_i, rst_i : clock and synchronous active-high reset. Reset empties
//                  the FIFO.
//   push_i       : write data_i at the tail this cycle.
//   data_i       : data to push.
//   pop_i        : drop the head entry this cycle.
//   head_o       : current head entry. It is only meaningful when the FIFO
//                  is not empty.
//   full_o       : DEPTH entries are held.
//   empty_o      : no entries are held.
//
// A push is ignored when full, unless a pop happens in the same cycle. A pop
// is ignored when empty. DEPTH must be a power of two, so the pointers wrap
// naturally.
// ---------------------------------------------------------------------------
module vproc_mem_arb_fifo #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic push_en;
  logic pop_en;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  always_comb begin
    pop_en   = pop_i & ~empty_o;
    // A pop in the same cycle frees a slot, so a push is allowed even when full.
    push_en  = push_i & (~full_o | pop_en);

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (push_en) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end

    if (pop_en) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    case ({push_en, pop_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/vproc_mem_arbiter.sv
// ---------------------------------------------------------------------------
// vproc_mem_arbiter
//   Shares one memory port between two requesters: instruction (rq0) and
//   data (rq1). Requests are arbitrated round-robin. Responses return in
//   order and are routed back to the requester that issued them, using an
//   ID FIFO.
//
// Handshake
//   A requester holds rqN_req_i and its request fields stable until
//   rqN_gnt_o is high in the same cycle. That cycle is the transfer.
//   mem_req_o is a valid with an implicit always-ready memory: every cycle
//   with mem_req_o high is one issued request. Every issued request returns
//   exactly one mem_rvalid_i pulse, in issue order. That pulse is forwarded
//   in the same cycle as rqN_rvalid_o (with rqN_err_o) to the owning
//   requester. Requesters must always accept responses.
//
// Ports
//   clk_i, rst_i                   : clock, synchronous active-high reset.
//   rqN_req_i/addr/we/be/wdata     : request from requester N.
//   rqN_gnt_o                      : request of requester N accepted.
//   rqN_rvalid_o/err_o/rdata_o     : response to requester N.
//   mem_req_o/addr/we/be/wdata     : request to memory.
//   mem_rvalid_i/err_i/rdata_i     : response from memory.
//   spurious_o                     : a response arrived with nothing
//                                    outstanding.
// ---------------------------------------------------------------------------
module vproc_mem_arbiter
  import vproc_pkg::*;
#(
  parameter int unsigned MEM_W           = 32,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,

  input  logic               rq0_req_i,
  output logic               rq0_gnt_o,
  input  logic [31:0]        rq0_addr_i,
  input  logic               rq0_we_i,
  input  logic [MEM_W/8-1:0] rq0_be_i,
  input  logic [MEM_W-1:0]   rq0_wdata_i,
  output logic               rq0_rvalid_o,
  output logic               rq0_err_o,
  output logic [MEM_W-1:0]   rq0_rdata_o,

  input  logic               rq1_req_i,
  output logic               rq1_gnt_o,
  input  logic [31:0]        rq1_addr_i,
  input  logic               rq1_we_i,
  input  logic [MEM_W/8-1:0] rq1_be_i,
  input  logic [MEM_W-1:0]   rq1_wdata_i,
  output logic               rq1_rvalid_o,
  output logic               rq1_err_o,
  output logic [MEM_W-1:0]   rq1_rdata_o,

  output logic               mem_req_o,
  output logic [31:0]        mem_addr_o,
  output logic               mem_we_o,
  output logic [MEM_W/8-1:0] mem_be_o,
  output logic [MEM_W-1:0]   mem_wdata_o,
  input  logic               mem_rvalid_i,
  input  logic               mem_err_i,
  input  logic [MEM_W-1:0]   mem_rdata_i,

  output logic               spurious_o
);

  // Round-robin priority pointer: the port that wins when both request.
  req_id_e prio_q, prio_d;
  req_id_e winner;
  logic    grant;

  logic                fifo_full;
  logic                fifo_empty;
  logic [REQ_ID_W-1:0] fifo_head;
  req_id_e             head_id;
  logic                rsp_route;

  // -------------------------------------------------------------------------
  // Request side
  // -------------------------------------------------------------------------
  always_comb begin
    winner = REQ_INSTR;
    if (rq0_req_i && rq1_req_i) begin
      winner = prio_q;
    end else if (rq1_req_i) begin
      winner = REQ_DATA;
    end

    // Grant depends only on the registered occupancy, never on
    // mem_rvalid_i. A slot freed by a response can be reused from the next
    // cycle on, so there is no rvalid-to-req combinational path.
    grant     = (rq0_req_i | rq1_req_i) & ~fifo_full & ~rst_i;

    mem_req_o = grant;
    rq0_gnt_o = grant & (winner == REQ_INSTR);
    rq1_gnt_o = grant & (winner == REQ_DATA);

    if (winner == REQ_DATA) begin
      mem_addr_o  = rq1_addr_i;
      mem_we_o    = rq1_we_i;
      mem_be_o    = rq1_be_i;
      mem_wdata_o = rq1_wdata_i;
    end else begin
      mem_addr_o  = rq0_addr_i;
      mem_we_o    = rq0_we_i;
      mem_be_o    = rq0_be_i;
      mem_wdata_o = rq0_wdata_i;
    end

    // After every grant, priority passes to the port that did not win.
    // With no grant, the pointer holds.
    prio_d = grant ? other_req(winner) : prio_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prio_q <= REQ_INSTR;
    end else begin
      prio_q <= prio_d;
    end
  end

  // -------------------------------------------------------------------------
  // Ownership FIFO: one entry per issued, unanswered request
  // -------------------------------------------------------------------------
  vproc_mem_arb_fifo #(
    .WIDTH (REQ_ID_W),
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (grant),
    .data_i  (winner),
    .pop_i   (rsp_route),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // -------------------------------------------------------------------------
  // Response side
  // -------------------------------------------------------------------------
  // The head entry reflects registered state only. A request granted this
  // cycle therefore cannot be matched with a response in the same cycle.
  always_comb begin
    head_id      = req_id_e'(fifo_head);
    rsp_route    = mem_rvalid_i & ~fifo_empty & ~rst_i;
    spurious_o   = mem_rvalid_i &  fifo_empty & ~rst_i;

    rq0_rvalid_o = rsp_route & (head_id == REQ_INSTR);
    rq1_rvalid_o = rsp_route & (head_id == REQ_DATA);
    rq0_err_o    = rq0_rvalid_o & mem_err_i;
    rq1_err_o    = rq1_rvalid_o & mem_err_i;

    // Read data fans out to both ports; rvalid qualifies it.
    rq0_rdata_o  = mem_rdata_i;
    rq1_rdata_o  = mem_rdata_i;
  end

endmodule

// File: tb/tb_vproc_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vproc_mem_arbiter
//   Directed bench for vproc_mem_arbiter. It contains a fixed-latency
//   in-order memory model, per-port request drivers, and a monitor that
//   checks grants and responses against expected queues.
// ---------------------------------------------------------------------------
module tb_vproc_mem_arbiter;

  localparam int MEM_W = 32;
  localparam int BE_W  = MEM_W / 8;

  typedef struct {
    int          port;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          cyc;
  } req_t;

  typedef struct {
    int          due;
    logic        err;
    logic [31:0] rdata;
  } mem_rsp_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_i;
  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------- DUT ----------------
  logic             rq0_req_i, rq0_gnt_o, rq0_we_i, rq0_rvalid_o, rq0_err_o;
  logic [31:0]      rq0_addr_i;
  logic [BE_W-1:0]  rq0_be_i;
  logic [MEM_W-1:0] rq0_wdata_i, rq0_rdata_o;
  logic             rq1_req_i, rq1_gnt_o, rq1_we_i, rq1_rvalid_o, rq1_err_o;
  logic [31:0]      rq1_addr_i;
  logic [BE_W-1:0]  rq1_be_i;
  logic [MEM_W-1:0] rq1_wdata_i, rq1_rdata_o;
  logic             mem_req_o, mem_we_o, mem_rvalid_i, mem_err_i, spurious_o;
  logic [31:0]      mem_addr_o;
  logic [BE_W-1:0]  mem_be_o;
  logic [MEM_W-1:0] mem_wdata_o, mem_rdata_i;

  vproc_mem_arbiter #(.MEM_W(MEM_W), .MAX_OUTSTANDING(4)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .rq0_req_i(rq0_req_i), .rq0_gnt_o(rq0_gnt_o), .rq0_addr_i(rq0_addr_i),
    .rq0_we_i(rq0_we_i), .rq0_be_i(rq0_be_i), .rq0_wdata_i(rq0_wdata_i),
    .rq0_rvalid_o(rq0_rvalid_o), .rq0_err_o(rq0_err_o), .rq0_rdata_o(rq0_rdata_o),
    .rq1_req_i(rq1_req_i), .rq1_gnt_o(rq1_gnt_o), .rq1_addr_i(rq1_addr_i),
    .rq1_we_i(rq1_we_i), .rq1_be_i(rq1_be_i), .rq1_wdata_i(rq1_wdata_i),
    .rq1_rvalid_o(rq1_rvalid_o), .rq1_err_o(rq1_err_o), .rq1_rdata_o(rq1_rdata_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
    .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_rvalid_i(mem_rvalid_i),
    .mem_err_i(mem_err_i), .mem_rdata_i(mem_rdata_i), .spurious_o(spurious_o)
  );

  // ---------------- scoreboard state ----------------
  req_t        q0[$];
  req_t        q1[$];
  req_t        exp_gnt_q[$];
  logic [33:0] exp_q[$];     // {port, err, rdata}
  mem_rsp_t    pend_q[$];
  int          lat = 1;
  logic        inject_spur = 1'b0;
  int          checks = 0;
  int          errors = 0;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return a ^ 32'hC0DE_1234;
  endfunction

  function automatic void chk(input string name, input logic [63:0] act,
                              input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic issue(input int port, input logic [31:0] addr, input logic we,
                       input logic [3:0] be, input logic [31:0] wdata,
                       input int exp_cyc);
    req_t r;
    r.port = port; r.addr = addr; r.we = we; r.be = be; r.wdata = wdata;
    r.cyc = exp_cyc;
    if (port == 0) q0.push_back(r);
    else           q1.push_back(r);
    exp_gnt_q.push_back(r);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((exp_gnt_q.size() + exp_q.size() + pend_q.size() + q0.size() + q1.size()) != 0
           && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (n >= budget) begin
      chk("idle_timeout", 64'(n), 64'(budget - 1));
      q0.delete(); q1.delete(); exp_gnt_q.delete(); exp_q.delete(); pend_q.delete();
    end
    repeat (2) @(posedge clk);
    #2;
  endtask

  initial begin
    rq0_req_i = 0; rq0_addr_i = 0; rq0_we_i = 0; rq0_be_i = 0; rq0_wdata_i = 0;
    forever begin
      @(posedge clk); #1;
      if (q0.size() > 0) begin
        rq0_req_i = 1; rq0_addr_i = q0[0].addr; rq0_we_i = q0[0].we;
        rq0_be_i = q0[0].be; rq0_wdata_i = q0[0].wdata;
      end else begin
        rq0_req_i = 0;
      end
    end
  end

  initial begin
    rq1_req_i = 0; rq1_addr_i = 0; rq1_we_i = 0; rq1_be_i = 0; rq1_wdata_i = 0;
    forever begin
      @(posedge clk); #1;
      if (q1.size() > 0) begin
        rq1_req_i = 1; rq1_addr_i = q1[0].addr; rq1_we_i = q1[0].we;
        rq1_be_i = q1[0].be; rq1_wdata_i = q1[0].wdata;
      end else begin
        rq1_req_i = 0;
      end
    end
  end

  // ---------------- memory model + monitor ----------------
  initial begin
    logic [33:0] e;
    req_t        g;
    int          gp;
    mem_rsp_t    m;
    mem_rvalid_i = 0; mem_err_i = 0; mem_rdata_i = 0;
    forever begin
      @(negedge clk);
      if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
        m = pend_q.pop_front();
        mem_rvalid_i = 1; mem_err_i = m.err; mem_rdata_i = m.rdata;
      end else if (inject_spur) begin
        mem_rvalid_i = 1; mem_err_i = 0; mem_rdata_i = 32'h5A5A_5A5A;
        inject_spur = 0;
      end else begin
        mem_rvalid_i = 0; mem_err_i = 0;
        mem_rdata_i = 32'($urandom_range(65535, 0));
      end
      #1;
      if (rst_i) begin
        chk("reset_outputs",
            64'({mem_req_o, rq0_gnt_o, rq1_gnt_o, rq0_rvalid_o, rq1_rvalid_o,
                 rq0_err_o, rq1_err_o, spurious_o}), 64'(0));
        exp_q.delete();
      end else begin
        chk("gnt_onehot",
            64'({rq0_gnt_o | rq1_gnt_o, rq0_gnt_o & rq1_gnt_o}), 64'({mem_req_o, 1'b0}));
        if (mem_rvalid_i && exp_q.size() == 0) begin
          chk("spurious_rsp",
              64'({spurious_o, rq1_rvalid_o, rq0_rvalid_o, rq1_err_o, rq0_err_o}),
              64'(5'b10000));
        end else if (mem_rvalid_i) begin
          e = exp_q.pop_front();
          chk("rsp_route", 64'({spurious_o, rq1_rvalid_o, rq0_rvalid_o}),
              64'({1'b0, e[33], ~e[33]}));
          chk("rsp_err", 64'({rq1_err_o, rq0_err_o}),
              64'({e[33] & e[32], ~e[33] & e[32]}));
          chk("rsp_rdata", {rq1_rdata_o, rq0_rdata_o}, {e[31:0], e[31:0]});
        end else begin
          chk("idle_rsp",
              64'({spurious_o, rq1_rvalid_o, rq0_rvalid_o, rq1_err_o, rq0_err_o}),
              64'(0));
        end
        if (rq0_gnt_o || rq1_gnt_o) begin
          gp = rq1_gnt_o ? 1 : 0;
          if (exp_gnt_q.size() == 0) begin
            chk("unexpected_grant", 64'(gp + 1), 64'(0));
          end else begin
            g = exp_gnt_q.pop_front();
            chk("gnt_port", 64'(gp), 64'(g.port));
            chk("mem_addr", 64'(mem_addr_o), 64'(g.addr));
            chk("mem_we_be", 64'({mem_we_o, mem_be_o}), 64'({g.we, g.be}));
            chk("mem_wdata", 64'(mem_wdata_o), 64'(g.wdata));
            if (g.cyc >= 0) chk("gnt_cycle", 64'(cyc), 64'(g.cyc));
            exp_q.push_back({g.port[0], g.addr[31], mem_fn(g.addr)});
          end
          m.due = cyc + lat; m.err = mem_addr_o[31]; m.rdata = mem_fn(mem_addr_o);
          pend_q.push_back(m);
          if (gp == 1 && q1.size() > 0) void'(q1.pop_front());
          if (gp == 0 && q0.size() > 0) void'(q0.pop_front());
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int b;
    int n;
    rst_i = 1;
    repeat (3) @(posedge clk);
    #1 rst_i = 0;
    @(posedge clk); #2;

    // Both ports contend from reset: grants alternate 0,1,0,1,0,1.
    lat = 2; b = cyc;
    issue(0, 32'h10, 0, 4'hF, 0, b + 1);
    issue(1, 32'h14, 0, 4'hF, 0, b + 2);
    issue(0, 32'h18, 0, 4'hF, 0, b + 3);
    issue(1, 32'h1C, 0, 4'hF, 0, b + 4);
    issue(0, 32'h20, 0, 4'hF, 0, b + 5);
    issue(1, 32'h24, 0, 4'hF, 0, b + 6);
    wait_idle(40);

    // Single rq0 read, latency 1.
    lat = 1; b = cyc;
    issue(0, 32'h100, 0, 4'hF, 0, b + 1);
    wait_idle(20);

    // Latency 10: four grants fill the FIFO; the fifth waits for the first
    // response (cycle b+11) and is granted in the cycle after it.
    lat = 10; b = cyc;
    for (int i = 0; i < 5; i++)
      issue(1, 32'h400 + 32'(4 * i), 0, 4'hF, 0, (i < 4) ? b + 1 + i : b + 12);
    wait_idle(80);

    // rq1 write, fields must pass through exactly.
    lat = 3; b = cyc;
    issue(1, 32'h200, 1, 4'b0011, 32'hDEAD_BEEF, b + 1);
    wait_idle(20);

    // Error response to rq0 only.
    lat = 2; b = cyc;
    issue(0, 32'h8000_0000, 0, 4'hF, 0, b + 1);
    wait_idle(20);

    // Response with nothing outstanding.
    inject_spur = 1;
    repeat (3) @(posedge clk); #2;

    // Three outstanding, then reset: their late responses become spurious.
    lat = 10; b = cyc;
    for (int i = 0; i < 3; i++) issue(0, 32'h300 + 32'(4 * i), 0, 4'hF, 0, b + 1 + i);
    n = 0;
    while (exp_gnt_q.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    if (n >= 20) chk("gnt_wait_timeout", 64'(n), 64'(19));
    #1 rst_i = 1;
    repeat (2) @(posedge clk);
    #1 rst_i = 0;
    wait_idle(40);

    // Normal arbitration after reset, pointer back at port 0.
    lat = 2; b = cyc;
    issue(0, 32'h500, 0, 4'hF, 0, b + 1);
    issue(1, 32'h504, 0, 4'hF, 0, b + 2);
    wait_idle(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vproc_mem_arbiter.md
VPROC_MEM_ARBITER -- requirements
Module: vproc_mem_arbiter

Interface
REQ-001 SHALL have parameter MEM_W, default 32, memory data width in bits (multiple of 32).
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 4, maximum number of issued but unanswered memory requests (power of two, >= 2).
REQ-003 SHALL have port clk_i  input  1  clock; one clock, all logic on rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-005 SHALL have, for each requester n in {0 (instruction), 1 (data)}: rqN_req_i input 1 request; rqN_gnt_o output 1 accepted this cycle; rqN_addr_i input 32; rqN_we_i input 1; rqN_be_i input MEM_W/8; rqN_wdata_i input MEM_W; rqN_rvalid_o output 1 response valid; rqN_err_o output 1 response error; rqN_rdata_o output MEM_W.
REQ-006 SHALL have memory-side ports mem_req_o output 1; mem_addr_o output 32; mem_we_o output 1; mem_be_o output MEM_W/8; mem_wdata_o output MEM_W; mem_rvalid_i input 1; mem_err_i input 1; mem_rdata_i input MEM_W.
REQ-007 SHALL have port spurious_o  output 1  one-cycle pulse on a response with nothing outstanding.

Function
REQ-008 Memory SHALL be modelled as always-accepting, in-order responder: every request (read or write) yields exactly one mem_rvalid_i, after an arbitrary fixed latency >= 1 cycle.
REQ-009 Arbitration SHALL be combinational: mem_req_o = (rq0_req_i | rq1_req_i) & (count < MAX_OUTSTANDING).
REQ-010 Exactly one rqN_gnt_o SHALL be high when mem_req_o is high, none otherwise; mem_addr/we/be/wdata SHALL be the winning requester's inputs, muxed same cycle.
REQ-011 Single requester active: SHALL win. Both active: priority pointer wins; pointer SHALL move to the other port after every grant (round-robin), unchanged in cycles without grant.
REQ-012 On each grant the winner's ID (1 bit) SHALL be pushed into an in-order ID FIFO of depth MAX_OUTSTANDING.
REQ-013 On mem_rvalid_i with FIFO non-empty: head ID SHALL be popped, rqID_rvalid_o asserted same cycle (zero added latency), rqID_err_o = mem_err_i, rqID_rdata_o = mem_rdata_i.
REQ-014 rqN_rdata_o SHALL be driven by mem_rdata_i unconditionally; rqN_rvalid_o and rqN_err_o SHALL be 0 unless routed per REQ-013.
REQ-015 Simultaneous grant and response SHALL push and pop in the same cycle; count unchanged; responses to a request SHALL never be delivered in its grant cycle.
REQ-016 Full (count == MAX_OUTSTANDING): no grant, even if a response arrives the same cycle (no rvalid-to-req combinational path).
REQ-017 mem_rvalid_i with FIFO empty: no rqN_rvalid_o, spurious_o = 1 for that cycle, state unchanged.
REQ-018 FIFO pointers SHALL wrap modulo MAX_OUTSTANDING; count width $clog2(MAX_OUTSTANDING)+1.

Reset
REQ-019 While rst_i is high: all gnt/rvalid/err outputs, mem_req_o and spurious_o SHALL be 0; FIFO emptied (count 0); priority pointer = port 0.
REQ-020 Reset mid-operation SHALL discard outstanding IDs; responses arriving after reset release SHALL be treated per REQ-017.

Structure
REQ-021 vproc_pkg SHALL hold the requester ID typedef (1-bit enum: REQ_INSTR=0, REQ_DATA=1).
REQ-022 The ID FIFO SHALL be a sub-module vproc_mem_arb_fifo (params WIDTH, DEPTH; push, pop, full, empty, head data).
REQ-023 Implementation SHALL be 120-400 lines RTL, no latches, no memory macros.

Verification
REQ-024 Only rq0 requests addr 0x100 read; memory latency 1 -> rq0_gnt_o and mem_req_o same cycle, rq0_rvalid_o one cycle later with mem data, rq1_rvalid_o stays 0.
REQ-025 Both requesting continuously for 6 cycles after reset -> grants alternate 0,1,0,1,0,1; responses routed in the same order.
REQ-026 Memory latency 10, rq1 requests every cycle -> exactly 4 grants, then req held low until first response; grant resumes cycle after that response.
REQ-027 rq1 write addr 0x200 be 4'b0011 wdata 0xDEADBEEF -> memory-side fields match exactly; rq1_rvalid_o pulses once later.
REQ-028 Request to addr 0x8000_0000 with memory err -> requester's err_o=1 with its rvalid_o; other port untouched.
REQ-029 Inject mem_rvalid_i with nothing outstanding; separately assert rst_i with 3 outstanding -> spurious_o pulses, no rvalid on either port, arbiter grants normally afterwards.
